axis_8bit_adder: RTL and testbench
==================================

# axis_8bit_adder

Upstream stage of the 16-bit AXI-Stream receiver. Joins two 8-bit AXI-Stream operand channels, adds each accepted pair, and presents the sum, extended to 16 bits, on an AXI-Stream master. A 2-entry output buffer absorbs backpressure from the receiver's random-latency ready without dropping or duplicating results. A wrapping transaction counter exposes the number of sums delivered.

## Interface
- SIGNED, 0: 0 = operands unsigned, sum zero-extended; 1 = operands two's-complement, sum sign-extended.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-high
- s_axis_a_data  in  8  operand A
- s_axis_a_valid  in  1  A valid
- s_axis_a_ready  out  1  A ready
- s_axis_b_data  in  8  operand B
- s_axis_b_valid  in  1  B valid
- s_axis_b_ready  out  1  B ready
- m_axis_data  out  16  sum
- m_axis_valid  out  1  sum valid
- m_axis_ready  in  1  downstream ready (the receiver's s_axis_ready)
- sum_count  out  16  sums delivered on m_axis since reset, wraps 0xFFFF -> 0x0000

## Operation
- Join: a pair is accepted only in a cycle where s_axis_a_valid & s_axis_b_valid & ~full. Neither operand is consumed alone.
- s_axis_a_ready = s_axis_b_valid & ~full; s_axis_b_ready = s_axis_a_valid & ~full. Ready may depend on the other channel's valid, never on its own channel's valid.
- full is decoded from the registered buffer occupancy only (occ == 2), not from m_axis_ready.
- Sum: 9-bit result of A+B. SIGNED=0: {7'b0, A+B}, range 0..510. SIGNED=1: sign-extended 9-bit signed sum, range -256..254. No overflow is possible in 16 bits.
- Buffer: 2-entry FIFO, occupancy 0/1/2.
  - Push on accept.
  - Pop on m_axis_valid & m_axis_ready.
  - Push and pop in the same cycle: occupancy unchanged, order preserved.
- m_axis_valid = (occ != 0). m_axis_data = head entry, held stable while valid & ~ready.
- sum_count increments by 1 on each pop.
- Reset values: m_axis_valid 0, m_axis_data 0x0000, s_axis_a_ready 0, s_axis_b_ready 0 (both follow the decode above once rst deasserts), sum_count 0, occ 0.
- Reset asserted mid-operation: buffered sums are discarded and never emitted. Operands presented during reset are not accepted.

## Timing
- Latency: accept in cycle N -> m_axis_valid=1 with that sum in cycle N+1 when the buffer was empty.
- Throughput: 1 pair/cycle while m_axis_ready stays high.
- When full, readies drop in the same cycle occ reaches 2. They rise the cycle after the first pop, because ready is decoded from registered occupancy.
- m_axis_valid, once high, stays high with data unchanged until the handshake completes (AXI rule).
- m_axis_data, m_axis_valid and sum_count are registered outputs. The readies are combinational from registered occ and the other channel's valid.
- First accept possible in the first clock edge after rst falls.

## Structure
- Package axis_adder_pkg:
  - OPERAND_W=8, RESULT_W=16, COUNT_W=16, BUF_DEPTH=2.
  - Sum-extension function parameterised by SIGNED.
- Sub-module axis_fifo2: 2-entry register FIFO with push/pop/occ/head outputs.
- Top module contains the join logic, the adder and sum_count.

## Test plan
- Unsigned basic: A=0x12, B=0x34, m_axis_ready=1 -> next cycle m_axis_data=0x0046, valid=1; sum_count=1 after the handshake.
- Max/sign: SIGNED=0, A=B=0xFF -> 0x01FE. SIGNED=1, A=B=0x80 -> 0xFF00; A=0x7F, B=0x01 -> 0x0080.
- Join: A valid held 5 cycles with B valid low -> no accept, s_axis_a_ready=0, m_axis_valid=0. B then asserted -> exactly one sum emitted.
- Backpressure: m_axis_ready=0, feed pairs (1,1),(2,2),(3,3) -> first two accepted, readies low with (3,3) held. Release ready -> outputs 0x0002, 0x0004, 0x0006 in order, no loss or duplicates.
- Random-latency sink: drive m_axis_ready with 20-50 cycle low gaps, 1000 random pairs -> the scoreboard matches every sum in order; sum_count=1000.
- Reset mid-operation: buffer full, assert rst for 1 cycle -> m_axis_valid=0, sum_count=0 immediately. The discarded sums never appear. Normal flow resumes after rst deasserts. Counter wrap is checked by forcing 65536 pops -> 0x0000.

Source files
------------

// File: rtl/axis_8bit_adder_pkg.sv
// Shared widths, types and the sum-extension helper for the AXI-Stream adder slice.
package axis_adder_pkg;

    localparam int OPERAND_W = 8;
    localparam int RESULT_W  = 16;
    localparam int COUNT_W   = 16;
    localparam int BUF_DEPTH = 2;

    typedef logic [OPERAND_W-1:0] operand_t;
    typedef logic [RESULT_W-1:0]  result_t;
    typedef logic [COUNT_W-1:0]   count_t;

    // Output buffer occupancy; only these three values are reachable.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    // 9-bit sum of two operands, zero- or sign-extended to the result width.
    function automatic result_t extend_sum(input operand_t a, input operand_t b, input bit is_signed);
        logic [OPERAND_W:0] sum9;
        if (is_signed) begin
            sum9 = {a[OPERAND_W-1], a} + {b[OPERAND_W-1], b};
        end else begin
            sum9 = {1'b0, a} + {1'b0, b};
        end
        return {{(RESULT_W-OPERAND_W-1){is_signed & sum9[OPERAND_W]}}, sum9};
    endfunction

endpackage

// File: rtl/axis_8bit_adder_if.sv
// Bundles the two operand streams and the sum stream of the adder.
// The slave modport is the adder's view, the master modport the environment's.
interface axis_8bit_adder_if;
    import axis_adder_pkg::*;

    operand_t s_axis_a_data;
    logic     s_axis_a_valid;
    logic     s_axis_a_ready;
    operand_t s_axis_b_data;
    logic     s_axis_b_valid;
    logic     s_axis_b_ready;
    result_t  m_axis_data;
    logic     m_axis_valid;
    logic     m_axis_ready;

    modport slave (
        input  s_axis_a_data, s_axis_a_valid,
        output s_axis_a_ready,
        input  s_axis_b_data, s_axis_b_valid,
        output s_axis_b_ready,
        output m_axis_data, m_axis_valid,
        input  m_axis_ready
    );

    modport master (
        output s_axis_a_data, s_axis_a_valid,
        input  s_axis_a_ready,
        output s_axis_b_data, s_axis_b_valid,
        input  s_axis_b_ready,
        input  m_axis_data, m_axis_valid,
        output m_axis_ready
    );

endinterface

// File: rtl/axis_8bit_adder_fifo2.sv
// Two-entry register FIFO. The head lives in slot0 so the output data is
// always a plain register and never moves while the consumer stalls.
module axis_fifo2
    import axis_adder_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  result_t push_data,
    input  logic    pop,
    output result_t head,
    output occ_t    occ
);

    result_t slot0;
    result_t slot1;

    // Update storage and occupancy; simultaneous push/pop keeps the count and order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ   <= OCC_EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        slot0 <= push_data;
                        occ   <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        slot0 <= push_data;
                    end else if (push) begin
                        slot1 <= push_data;
                        occ   <= OCC_FULL;
                    end else if (pop) begin
                        occ <= OCC_EMPTY;
                    end
                end
                default: begin
                    if (pop) begin
                        slot0 <= slot1;
                        occ   <= OCC_ONE;
                    end
                end
            endcase
        end
    end

    assign head = slot0;

endmodule

// File: rtl/axis_8bit_adder.sv
// Joins two 8-bit operand streams, adds each accepted pair and streams the
// extended sum out through a 2-entry buffer, counting delivered sums.
module axis_8bit_adder
    import axis_adder_pkg::*;
#(
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    axis_8bit_adder_if.slave bus,
    output count_t           sum_count
);

    occ_t    occ;
    result_t head;
    result_t sum;
    logic    full;
    logic    accept;
    logic    pop;
    logic    m_valid;

    // Readies come from registered occupancy and the other channel's valid only,
    // and are held low during reset so nothing is taken while rst is high.
    assign full               = (occ == OCC_FULL);
    assign bus.s_axis_a_ready = ~rst & bus.s_axis_b_valid & ~full;
    assign bus.s_axis_b_ready = ~rst & bus.s_axis_a_valid & ~full;
    assign accept             = ~rst & bus.s_axis_a_valid & bus.s_axis_b_valid & ~full;

    assign m_valid            = (occ != OCC_EMPTY);
    assign pop                = m_valid & bus.m_axis_ready;
    assign bus.m_axis_valid   = m_valid;
    assign bus.m_axis_data    = head;

    assign sum = extend_sum(bus.s_axis_a_data, bus.s_axis_b_data, SIGNED);

    axis_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (sum),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    // Count every completed output handshake; wraps naturally at the width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_count <= '0;
        end else if (pop) begin
            sum_count <= sum_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_8bit_adder.sv
// Directed bench for axis_8bit_adder: unsigned and signed instances, join,
// backpressure, random-latency sink, mid-run reset and counter wrap.
module tb_axis_8bit_adder;
    import axis_adder_pkg::*;

    localparam int NUM_RANDOM = 1000;

    logic   clk = 1'b0;
    logic   rst;
    count_t u_count;
    count_t s_count;
    int     total;
    int     bad;
    int     exp_count;

    axis_8bit_adder_if u_bus ();
    axis_8bit_adder_if s_bus ();

    axis_8bit_adder #(.SIGNED(1'b0)) dut_u (
        .clk       (clk),
        .rst       (rst),
        .bus       (u_bus),
        .sum_count (u_count)
    );

    axis_8bit_adder #(.SIGNED(1'b1)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .bus       (s_bus),
        .sum_count (s_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        u_bus.s_axis_a_data = 8'd3;  u_bus.s_axis_b_data = 8'd4;
        u_bus.s_axis_a_valid = 1'b1; u_bus.s_axis_b_valid = 1'b1;
        u_bus.m_axis_ready = 1'b0;
        s_bus.s_axis_a_data = 8'd0;  s_bus.s_axis_b_data = 8'd0;
        s_bus.s_axis_a_valid = 1'b0; s_bus.s_axis_b_valid = 1'b0;
        s_bus.m_axis_ready = 1'b1;
        tick();
        tick();
        total++; if (u_bus.s_axis_a_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_a_ready: got %b want 0", u_bus.s_axis_a_ready); end
        total++; if (u_bus.s_axis_b_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_b_ready: got %b want 0", u_bus.s_axis_b_ready); end
        total++; if (u_bus.m_axis_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", u_bus.m_axis_valid); end
        total++; if (u_bus.m_axis_data !== 16'h0000) begin bad++; $display("[TB] FAIL reset_data: got %h want 0000", u_bus.m_axis_data); end
        total++; if (u_count !== 16'h0000) begin bad++; $display("[TB] FAIL reset_count: got %h want 0000", u_count); end
        rst = 1'b0;
        #1;
        total++; if (u_bus.s_axis_a_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_ready: got %b want 1", u_bus.s_axis_a_ready); end
        tick();
        total++; if (u_bus.m_axis_valid !== 1'b1 || u_bus.m_axis_data !== 16'h0007) begin
            bad++; $display("[TB] FAIL first_accept: got valid=%b data=%h want 1/0007", u_bus.m_axis_valid, u_bus.m_axis_data); end
        u_bus.s_axis_a_valid = 1'b0; u_bus.s_axis_b_valid = 1'b0;
        u_bus.m_axis_ready = 1'b1;
        tick();
        exp_count = 1;
        total++; if (u_bus.m_axis_valid !== 1'b0 || u_count !== count_t'(exp_count)) begin
            bad++; $display("[TB] FAIL first_drain: got valid=%b count=%0d want 0/%0d", u_bus.m_axis_valid, u_count, exp_count); end
    endtask

    task automatic test_signed();
        operand_t sa[4];
        operand_t sb[4];
        result_t  sexp[4];
        sa   = '{8'h80, 8'h7F, 8'hFF, 8'hFF};
        sb   = '{8'h80, 8'h01, 8'h01, 8'hFF};
        sexp = '{16'hFF00, 16'h0080, 16'h0000, 16'hFFFE};
        for (int i = 0; i < 4; i++) begin
            s_bus.s_axis_a_data = sa[i]; s_bus.s_axis_b_data = sb[i];
            s_bus.s_axis_a_valid = 1'b1; s_bus.s_axis_b_valid = 1'b1;
            tick();
            s_bus.s_axis_a_valid = 1'b0; s_bus.s_axis_b_valid = 1'b0;
            total++; if (s_bus.m_axis_valid !== 1'b1 || s_bus.m_axis_data !== sexp[i]) begin
                bad++; $display("[TB] FAIL signed_sum%0d: got valid=%b data=%h want 1/%h", i, s_bus.m_axis_valid, s_bus.m_axis_data, sexp[i]); end
            tick();
        end
        total++; if (s_count !== 16'd4) begin bad++; $display("[TB] FAIL signed_count: got %0d want 4", s_count); end
    endtask

    task automatic test_basic();
        operand_t ua[4];
        operand_t ub[4];
        result_t  uexp[4];
        ua   = '{8'h12, 8'hFF, 8'h00, 8'h80};
        ub   = '{8'h34, 8'hFF, 8'h00, 8'h80};
        uexp = '{16'h0046, 16'h01FE, 16'h0000, 16'h0100};
        u_bus.m_axis_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            u_bus.s_axis_a_data = ua[i]; u_bus.s_axis_b_data = ub[i];
            u_bus.s_axis_a_valid = 1'b1; u_bus.s_axis_b_valid = 1'b1;
            tick();
            u_bus.s_axis_a_valid = 1'b0; u_bus.s_axis_b_valid = 1'b0;
            total++; if (u_bus.m_axis_valid !== 1'b1 || u_bus.m_axis_data !== uexp[i]) begin
                bad++; $display("[TB] FAIL unsigned_sum%0d: got valid=%b data=%h want 1/%h", i, u_bus.m_axis_valid, u_bus.m_axis_data, uexp[i]); end
            tick();
            exp_count++;
            total++; if (u_bus.m_axis_valid !== 1'b0 || u_count !== count_t'(exp_count)) begin
                bad++; $display("[TB] FAIL unsigned_drain%0d: got valid=%b count=%0d want 0/%0d", i, u_bus.m_axis_valid, u_count, exp_count); end
        end
    endtask

    task automatic test_join();
        u_bus.m_axis_ready = 1'b1;
        u_bus.s_axis_a_data = 8'd5; u_bus.s_axis_a_valid = 1'b1;
        u_bus.s_axis_b_data = 8'd6; u_bus.s_axis_b_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (u_bus.s_axis_a_ready !== 1'b0 || u_bus.s_axis_b_ready !== 1'b1 || u_bus.m_axis_valid !== 1'b0) begin
                bad++; $display("[TB] FAIL join_wait%0d: got a_rdy=%b b_rdy=%b valid=%b want 0/1/0", i,
                                u_bus.s_axis_a_ready, u_bus.s_axis_b_ready, u_bus.m_axis_valid); end
        end
        u_bus.s_axis_b_valid = 1'b1;
        #1;
        total++; if (u_bus.s_axis_a_ready !== 1'b1) begin bad++; $display("[TB] FAIL join_a_ready: got %b want 1", u_bus.s_axis_a_ready); end
        tick();
        u_bus.s_axis_a_valid = 1'b0; u_bus.s_axis_b_valid = 1'b0;
        total++; if (u_bus.m_axis_valid !== 1'b1 || u_bus.m_axis_data !== 16'h000B) begin
            bad++; $display("[TB] FAIL join_sum: got valid=%b data=%h want 1/000b", u_bus.m_axis_valid, u_bus.m_axis_data); end
        tick();
        exp_count++;
        total++; if (u_bus.m_axis_valid !== 1'b0 || u_count !== count_t'(exp_count)) begin
            bad++; $display("[TB] FAIL join_once: got valid=%b count=%0d want 0/%0d", u_bus.m_axis_valid, u_count, exp_count); end
    endtask

    task automatic test_back_to_back();
        operand_t ba[4];
        operand_t bb[4];
        result_t  bexp[4];
        ba   = '{8'h10, 8'h20, 8'h30, 8'h40};
        bb   = '{8'h01, 8'h02, 8'h03, 8'h04};
        bexp = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        u_bus.m_axis_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            u_bus.s_axis_a_data = ba[i]; u_bus.s_axis_b_data = bb[i];
            u_bus.s_axis_a_valid = 1'b1; u_bus.s_axis_b_valid = 1'b1;
            tick();
            total++; if (u_bus.m_axis_valid !== 1'b1 || u_bus.m_axis_data !== bexp[i] || u_bus.s_axis_a_ready !== 1'b1) begin
                bad++; $display("[TB] FAIL b2b_%0d: got valid=%b data=%h a_rdy=%b want 1/%h/1", i,
                                u_bus.m_axis_valid, u_bus.m_axis_data, u_bus.s_axis_a_ready, bexp[i]); end
        end
        u_bus.s_axis_a_valid = 1'b0; u_bus.s_axis_b_valid = 1'b0;
        tick();
        exp_count += 4;
        total++; if (u_bus.m_axis_valid !== 1'b0 || u_count !== count_t'(exp_count)) begin
            bad++; $display("[TB] FAIL b2b_drain: got valid=%b count=%0d want 0/%0d", u_bus.m_axis_valid, u_count, exp_count); end
    endtask

    task automatic test_backpressure();
        u_bus.m_axis_ready = 1'b0;
        u_bus.s_axis_a_data = 8'd1; u_bus.s_axis_b_data = 8'd1;
        u_bus.s_axis_a_valid = 1'b1; u_bus.s_axis_b_valid = 1'b1;
        tick();
        u_bus.s_axis_a_data = 8'd2; u_bus.s_axis_b_data = 8'd2;
        #1;
        total++; if (u_bus.s_axis_a_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_one: got %b want 1", u_bus.s_axis_a_ready); end
        tick();
        u_bus.s_axis_a_data = 8'd3; u_bus.s_axis_b_data = 8'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (u_bus.s_axis_a_ready !== 1'b0 || u_bus.s_axis_b_ready !== 1'b0 ||
                         u_bus.m_axis_valid !== 1'b1 || u_bus.m_axis_data !== 16'h0002) begin
                bad++; $display("[TB] FAIL bp_full%0d: got a_rdy=%b b_rdy=%b valid=%b data=%h want 0/0/1/0002", i,
                                u_bus.s_axis_a_ready, u_bus.s_axis_b_ready, u_bus.m_axis_valid, u_bus.m_axis_data); end
            tick();
        end
        u_bus.m_axis_ready = 1'b1;
        tick();
        total++; if (u_bus.m_axis_data !== 16'h0004 || u_bus.s_axis_a_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL bp_pop1: got data=%h a_rdy=%b want 0004/1", u_bus.m_axis_data, u_bus.s_axis_a_ready); end
        tick();
        u_bus.s_axis_a_valid = 1'b0; u_bus.s_axis_b_valid = 1'b0;
        total++; if (u_bus.m_axis_valid !== 1'b1 || u_bus.m_axis_data !== 16'h0006) begin
            bad++; $display("[TB] FAIL bp_pop2: got valid=%b data=%h want 1/0006", u_bus.m_axis_valid, u_bus.m_axis_data); end
        tick();
        exp_count += 3;
        total++; if (u_bus.m_axis_valid !== 1'b0 || u_count !== count_t'(exp_count)) begin
            bad++; $display("[TB] FAIL bp_drain: got valid=%b count=%0d want 0/%0d", u_bus.m_axis_valid, u_count, exp_count); end
    endtask

    task automatic test_random();
        result_t exp_q[$];
        int      sent;
        int      rcvd;
        sent = 0;
        rcvd = 0;
        u_bus.s_axis_a_valid = 1'b0; u_bus.s_axis_b_valid = 1'b0;
        u_bus.m_axis_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fork
            begin : producer
                bit       holding;
                int       guard;
                operand_t pa;
                operand_t pb;
                holding = 1'b0;
                guard   = 0;
                pa      = '0;
                pb      = '0;
                while (sent < NUM_RANDOM && guard < 40000) begin
                    @(posedge clk); #1;
                    guard++;
                    if (!holding) begin
                        if ($urandom_range(0, 3) == 0) begin
                            u_bus.s_axis_a_valid = 1'b0; u_bus.s_axis_b_valid = 1'b0;
                        end else begin
                            pa = operand_t'($urandom_range(0, 255));
                            pb = operand_t'($urandom_range(0, 255));
                            u_bus.s_axis_a_data = pa; u_bus.s_axis_b_data = pb;
                            u_bus.s_axis_a_valid = 1'b1; u_bus.s_axis_b_valid = 1'b1;
                            holding = 1'b1;
                        end
                    end
                    #3;
                    if (holding && u_bus.s_axis_a_ready && u_bus.s_axis_b_ready) begin
                        exp_q.push_back(result_t'(pa) + result_t'(pb));
                        sent++;
                        holding = 1'b0;
                    end
                end
                @(posedge clk); #1;
                u_bus.s_axis_a_valid = 1'b0; u_bus.s_axis_b_valid = 1'b0;
            end
            begin : consumer
                int      gap;
                int      guard;
                bit      rdy;
                bit      stalled;
                result_t held;
                result_t want;
                gap     = $urandom_range(20, 50);
                guard   = 0;
                rdy     = 1'b0;
                stalled = 1'b0;
                held    = '0;
                while (rcvd < NUM_RANDOM && guard < 40000) begin
                    @(posedge clk); #1;
                    guard++;
                    if (gap == 0) begin
                        rdy = ~rdy;
                        gap = rdy ? $urandom_range(5, 30) : $urandom_range(20, 50);
                    end
                    gap--;
                    u_bus.m_axis_ready = rdy;
                    #3;
                    if (stalled) begin
                        total++; if (u_bus.m_axis_valid !== 1'b1 || u_bus.m_axis_data !== held) begin
                            bad++; $display("[TB] FAIL rand_hold: got valid=%b data=%h want 1/%h", u_bus.m_axis_valid, u_bus.m_axis_data, held); end
                    end
                    if (u_bus.m_axis_valid && u_bus.m_axis_ready) begin
                        if (exp_q.size() == 0) begin
                            total++; bad++;
                            $display("[TB] FAIL rand_extra: got data=%h want no output", u_bus.m_axis_data);
                        end else begin
                            want = exp_q.pop_front();
                            total++; if (u_bus.m_axis_data !== want) begin
                                bad++; $display("[TB] FAIL rand_sum%0d: got %h want %h", rcvd, u_bus.m_axis_data, want); end
                        end
                        rcvd++;
                    end
                    stalled = u_bus.m_axis_valid && !u_bus.m_axis_ready;
                    held    = u_bus.m_axis_data;
                end
            end
        join
        tick();
        u_bus.m_axis_ready = 1'b1;
        total++; if (rcvd != NUM_RANDOM || sent != NUM_RANDOM) begin
            bad++; $display("[TB] FAIL rand_timeout: got sent=%0d rcvd=%0d want %0d", sent, rcvd, NUM_RANDOM); end
        total++; if (u_count !== count_t'(NUM_RANDOM)) begin
            bad++; $display("[TB] FAIL rand_count: got %0d want %0d", u_count, NUM_RANDOM); end
        tick();
        total++; if (u_bus.m_axis_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL rand_leftover: got valid=%b want 0", u_bus.m_axis_valid); end
    endtask

    task automatic test_reset_mid();
        u_bus.m_axis_ready = 1'b0;
        u_bus.s_axis_a_data = 8'd10; u_bus.s_axis_b_data = 8'd10;
        u_bus.s_axis_a_valid = 1'b1; u_bus.s_axis_b_valid = 1'b1;
        tick();
        u_bus.s_axis_a_data = 8'd20; u_bus.s_axis_b_data = 8'd20;
        tick();
        total++; if (u_bus.s_axis_a_ready !== 1'b0 || u_bus.m_axis_data !== 16'h0014) begin
            bad++; $display("[TB] FAIL mid_full: got a_rdy=%b data=%h want 0/0014", u_bus.s_axis_a_ready, u_bus.m_axis_data); end
        u_bus.s_axis_a_valid = 1'b0; u_bus.s_axis_b_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (u_bus.m_axis_valid !== 1'b0 || u_count !== 16'h0000 || u_bus.m_axis_data !== 16'h0000) begin
            bad++; $display("[TB] FAIL mid_reset: got valid=%b count=%h data=%h want 0/0000/0000",
                            u_bus.m_axis_valid, u_count, u_bus.m_axis_data); end
        tick();
        rst = 1'b0;
        u_bus.m_axis_ready = 1'b1;
        tick();
        total++; if (u_bus.m_axis_valid !== 1'b0 || u_count !== 16'h0000) begin
            bad++; $display("[TB] FAIL mid_discard: got valid=%b count=%0d want 0/0", u_bus.m_axis_valid, u_count); end
        u_bus.s_axis_a_data = 8'd7; u_bus.s_axis_b_data = 8'd8;
        u_bus.s_axis_a_valid = 1'b1; u_bus.s_axis_b_valid = 1'b1;
        tick();
        u_bus.s_axis_a_valid = 1'b0; u_bus.s_axis_b_valid = 1'b0;
        total++; if (u_bus.m_axis_valid !== 1'b1 || u_bus.m_axis_data !== 16'h000F) begin
            bad++; $display("[TB] FAIL mid_resume: got valid=%b data=%h want 1/000f", u_bus.m_axis_valid, u_bus.m_axis_data); end
        tick();
        total++; if (u_count !== 16'd1) begin bad++; $display("[TB] FAIL mid_count: got %0d want 1", u_count); end
    endtask

    task automatic test_wrap();
        u_bus.s_axis_a_valid = 1'b0; u_bus.s_axis_b_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        u_bus.s_axis_a_data = 8'd1; u_bus.s_axis_b_data = 8'd0;
        u_bus.s_axis_a_valid = 1'b1; u_bus.s_axis_b_valid = 1'b1;
        u_bus.m_axis_ready = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            tick();
        end
        total++; if (u_count !== 16'hFFFF || u_bus.m_axis_valid !== 1'b1 || u_bus.m_axis_data !== 16'h0001) begin
            bad++; $display("[TB] FAIL wrap_top: got count=%h valid=%b data=%h want ffff/1/0001",
                            u_count, u_bus.m_axis_valid, u_bus.m_axis_data); end
        tick();
        total++; if (u_count !== 16'h0000) begin bad++; $display("[TB] FAIL wrap_zero: got %h want 0000", u_count); end
        u_bus.s_axis_a_valid = 1'b0; u_bus.s_axis_b_valid = 1'b0;
        tick();
        total++; if (u_count !== 16'h0001 || u_bus.m_axis_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL wrap_after: got count=%h valid=%b want 0001/0", u_count, u_bus.m_axis_valid); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_count = 0;
        test_reset();
        test_signed();
        test_basic();
        test_join();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
